// File: rtl/arb_pkg.sv
// Shared types and constants for the four-requester memory port arbiter.
package arb_pkg;

    localparam int REQ_N           = 4;
    localparam int SEL_W           = 2;
    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    function automatic logic [REQ_N-1:0] onehot(input logic [SEL_W-1:0] s);
        return REQ_N'(1) << s;
    endfunction

endpackage

// File: rtl/mux4_32.sv
// Generic 4:1 32-bit select, shared by address and write-data paths.
module mux4_32 (
    input  logic [1:0]  sel_i,
    input  logic [31:0] d0_i,
    input  logic [31:0] d1_i,
    input  logic [31:0] d2_i,
    input  logic [31:0] d3_i,
    output logic [31:0] y_o
);

    always_comb begin
        unique case (sel_i)
            2'd0:    y_o = d0_i;
            2'd1:    y_o = d1_i;
            2'd2:    y_o = d2_i;
            default: y_o = d3_i;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: searches upward from last+1 (mod 4).
module rr_pick4
    import arb_pkg::*;
(
    input  logic [REQ_N-1:0] req_i,
    input  logic [SEL_W-1:0] last_i,
    output logic [SEL_W-1:0] sel_o,
    output logic             any_o
);

    logic [SEL_W-1:0] idx;

    // Walk from farthest to nearest so the nearest hit wins.
    always_comb begin
        sel_o = '0;
        any_o = 1'b0;
        idx   = '0;
        for (int i = REQ_N; i >= 1; i--) begin
            idx = last_i + SEL_W'(i);
            if (req_i[idx]) begin
                sel_o = idx;
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter of four requesters onto one memory port.
// Optional abort-on-timeout enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [3:0]  we,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] addr2,
    input  logic [31:0] addr3,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [31:0] wdata2,
    input  logic [31:0] wdata3,
    output logic [3:0]  gnt,
    output logic [3:0]  ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic [1:0]  sel,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [SEL_W-1:0] pick_sel;
    logic             pick_any;
    logic             busy;
    logic             tmo;
    logic             done;

    rr_pick4 u_pick (
        .req_i  (req),
        .last_i (last_q),
        .sel_o  (pick_sel),
        .any_o  (pick_any)
    );

    mux4_32 u_addr_mux (
        .sel_i (sel_q),
        .d0_i  (addr0),
        .d1_i  (addr1),
        .d2_i  (addr2),
        .d3_i  (addr3),
        .y_o   (mem_addr)
    );

    mux4_32 u_wdata_mux (
        .sel_i (sel_q),
        .d0_i  (wdata0),
        .d1_i  (wdata1),
        .d2_i  (wdata2),
        .d3_i  (wdata3),
        .y_o   (mem_wdata)
    );

    assign busy = (state_q == BUSY);

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tmo = busy && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    // Held at zero while idle, so every BUSY entry starts from 0.
    always_comb begin
        cnt_d = cnt_q;
        if (!busy) begin
            cnt_d = '0;
        end else if (!mem_ready && !tmo) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    assign done = busy && (mem_ready || tmo);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    sel_d   = pick_sel;
                    state_d = BUSY;
                end
            end
            default: begin
                if (done) begin
                    last_d  = sel_q;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= SEL_W'(REQ_N - 1);
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    assign sel       = sel_q;
    assign gnt       = busy ? onehot(sel_q) : '0;
    assign mem_valid = busy;
    assign mem_we    = busy && we[sel_q];
    assign ack       = done ? gnt : '0;
    assign rdata     = (busy && mem_ready) ? mem_rdata : '0;
    assign err       = tmo && !mem_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected acks queued at stimulus,
// compared by a monitor at every falling edge.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic [3:0]  ack;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [31:0] a [4];
    logic [31:0] wd [4];
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  sel;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        rd_fix_en;
    logic [31:0] rd_fix;

    exp_t sb [$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // Memory model: fixed word when forced, else inverted address.
    assign mem_rdata = rd_fix_en ? rd_fix : ~mem_addr;

    mem_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr0     (a[0]),
        .addr1     (a[1]),
        .addr2     (a[2]),
        .addr3     (a[3]),
        .wdata0    (wd[0]),
        .wdata1    (wd[1]),
        .wdata2    (wd[2]),
        .wdata3    (wd[3]),
        .gnt       (gnt),
        .ack       (ack),
        .rdata     (rdata),
        .err       (err),
        .sel       (sel),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always @(negedge clk) begin
        if (ack !== 4'b0) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL ack_unexpected ack=%b", ack);
            end else begin
                e = sb.pop_front();
                if (ack !== e.ack || rdata !== e.rdata || err !== e.err) begin
                    failures++;
                    $display("FAIL ack_data got ack=%b rdata=%h err=%b exp ack=%b rdata=%h err=%b",
                             ack, rdata, err, e.ack, e.rdata, e.err);
                end
            end
        end else begin
            checks++;
            if (err !== 1'b0 || rdata !== 32'h0) begin
                failures++;
                $display("FAIL idle_outputs err=%b rdata=%h exp 0", err, rdata);
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (gnt !== 4'b0 || ack !== 4'b0) begin
            failures++;
            $display("FAIL reset_gnt_ack gnt=%b ack=%b exp 0", gnt, ack);
        end
        checks++;
        if (mem_valid !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_mem valid=%b we=%b exp 0", mem_valid, mem_we);
        end
        checks++;
        if (sel !== 2'd0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_sel_err sel=%0d err=%b exp 0", sel, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_contention();
        logic [1:0] k2;
        @(posedge clk);
        #1;
        rd_fix_en = 1'b0;
        mem_ready = 1'b1;
        req       = 4'hF;
        for (int k = 0; k < 5; k++) begin
            k2 = 2'(k);
            sb.push_back('{4'(1 << k2), ~a[k2], 1'b0});
        end
        for (int k = 0; k < 5; k++) begin
            k2 = 2'(k);
            @(negedge clk);
            checks++;
            if (gnt !== 4'b0) begin
                failures++;
                $display("FAIL rr_idle k=%0d gnt=%b exp 0000", k, gnt);
            end
            @(negedge clk);
            checks++;
            if (gnt !== 4'(1 << k2) || sel !== k2) begin
                failures++;
                $display("FAIL rr_grant k=%0d gnt=%b sel=%0d exp sel=%0d",
                         k, gnt, sel, k2);
            end
        end
        @(posedge clk);
        #1;
        req       = 4'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_valid !== 1'b0) begin
            failures++;
            $display("FAIL rr_end_valid valid=%b exp 0", mem_valid);
        end
    endtask

    task automatic test_wrap();
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        req       = 4'b1000;
        sb.push_back('{4'b1000, ~a[3], 1'b0});
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (gnt !== 4'b1000) begin
            failures++;
            $display("FAIL wrap_g3 gnt=%b exp 1000", gnt);
        end
        @(posedge clk);
        #1;
        req = 4'b1001;
        sb.push_back('{4'b0001, ~a[0], 1'b0});
        sb.push_back('{4'b1000, ~a[3], 1'b0});
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL wrap_g0 gnt=%b exp 0001", gnt);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (gnt !== 4'b1000) begin
            failures++;
            $display("FAIL wrap_then3 gnt=%b exp 1000", gnt);
        end
        @(posedge clk);
        #1;
        req = 4'b1000;
        sb.push_back('{4'b1000, ~a[3], 1'b0});
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (gnt !== 4'b1000) begin
            failures++;
            $display("FAIL wrap_same_last gnt=%b exp 1000", gnt);
        end
        @(posedge clk);
        #1;
        req       = 4'b0;
        mem_ready = 1'b0;
    endtask

    task automatic test_single();
        @(posedge clk);
        #1;
        a[1]      = 32'h0000_0040;
        we        = 4'b0;
        rd_fix_en = 1'b1;
        rd_fix    = 32'hDEAD_BEEF;
        req       = 4'b0010;
        sb.push_back('{4'b0010, 32'hDEAD_BEEF, 1'b0});
        @(posedge clk);
        #1;
        checks++;
        if (mem_valid !== 1'b1 || sel !== 2'd1 || gnt !== 4'b0010) begin
            failures++;
            $display("FAIL single_grant valid=%b sel=%0d gnt=%b exp 1 1 0010",
                     mem_valid, sel, gnt);
        end
        checks++;
        if (mem_addr !== 32'h40 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL single_addr addr=%h we=%b exp 00000040 0",
                     mem_addr, mem_we);
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        req       = 4'b0;
        rd_fix_en = 1'b0;
        checks++;
        if (mem_valid !== 1'b0 || gnt !== 4'b0) begin
            failures++;
            $display("FAIL single_idle valid=%b gnt=%b exp 0", mem_valid, gnt);
        end
    endtask

    task automatic test_write_hold();
        @(posedge clk);
        #1;
        we    = 4'b0100;
        wd[2] = 32'h1234_5678;
        req   = 4'b0100;
        sb.push_back('{4'b0100, ~a[2], 1'b0});
        sb.push_back('{4'b0001, ~a[0], 1'b0});
        @(posedge clk);
        #1;
        checks++;
        if (mem_we !== 1'b1 || mem_wdata !== 32'h1234_5678 || gnt !== 4'b0100) begin
            failures++;
            $display("FAIL write_busy we=%b wdata=%h gnt=%b exp 1 12345678 0100",
                     mem_we, mem_wdata, gnt);
        end
        req = 4'b0001;
        @(posedge clk);
        #1;
        checks++;
        if (gnt !== 4'b0100 || sel !== 2'd2 || mem_we !== 1'b1) begin
            failures++;
            $display("FAIL write_no_preempt gnt=%b sel=%0d we=%b exp 0100 2 1",
                     gnt, sel, mem_we);
        end
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (mem_we !== 1'b0 || gnt !== 4'b0) begin
            failures++;
            $display("FAIL write_idle we=%b gnt=%b exp 0", mem_we, gnt);
        end
        @(posedge clk);
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL write_next gnt=%b exp 0001", gnt);
        end
        @(posedge clk);
        #1;
        req       = 4'b0;
        we        = 4'b0;
        mem_ready = 1'b0;
    endtask

    task automatic test_reset_busy();
        @(posedge clk);
        #1;
        req = 4'b0100;
        @(posedge clk);
        #1;
        checks++;
        if (mem_valid !== 1'b1) begin
            failures++;
            $display("FAIL rstb_busy valid=%b exp 1", mem_valid);
        end
        #2;
        rst_n = 1'b0;
        req   = 4'b0;
        #1;
        checks++;
        if (mem_valid !== 1'b0 || gnt !== 4'b0 || ack !== 4'b0) begin
            failures++;
            $display("FAIL rstb_drop valid=%b gnt=%b ack=%b exp 0",
                     mem_valid, gnt, ack);
        end
        @(posedge clk);
        #3;
        rst_n     = 1'b1;
        req       = 4'b1001;
        mem_ready = 1'b1;
        sb.push_back('{4'b0001, ~a[0], 1'b0});
        @(posedge clk);
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL rstb_regrant gnt=%b exp 0001", gnt);
        end
        @(posedge clk);
        #1;
        req       = 4'b0;
        mem_ready = 1'b0;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        @(posedge clk);
        #1;
        req       = 4'b0001;
        mem_ready = 1'b0;
        sb.push_back('{4'b0001, 32'h0, 1'b1});
        @(posedge clk);
        #1;
        checks++;
        if (mem_valid !== 1'b1) begin
            failures++;
            $display("FAIL tmo_start valid=%b exp 1", mem_valid);
        end
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (c == 8) begin
                checks++;
                if (ack !== 4'b0001 || err !== 1'b1) begin
                    failures++;
                    $display("FAIL tmo_abort ack=%b err=%b exp 0001 1", ack, err);
                end
            end else begin
                checks++;
                if (ack !== 4'b0) begin
                    failures++;
                    $display("FAIL tmo_early c=%0d ack=%b exp 0", c, ack);
                end
            end
        end
        @(posedge clk);
        #1;
        req = 4'b0;
        checks++;
        if (mem_valid !== 1'b0) begin
            failures++;
            $display("FAIL tmo_idle valid=%b exp 0", mem_valid);
        end
    endtask
`else
    task automatic test_no_timeout();
        @(posedge clk);
        #1;
        req       = 4'b0001;
        mem_ready = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        checks++;
        if (mem_valid !== 1'b1 || ack !== 4'b0 || gnt !== 4'b0001) begin
            failures++;
            $display("FAIL wait_forever valid=%b ack=%b gnt=%b exp 1 0000 0001",
                     mem_valid, ack, gnt);
        end
        sb.push_back('{4'b0001, ~a[0], 1'b0});
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        req       = 4'b0;
        mem_ready = 1'b0;
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        req       = 4'b0;
        we        = 4'b0;
        mem_ready = 1'b0;
        rd_fix_en = 1'b0;
        rd_fix    = 32'h0;
        for (int i = 0; i < 4; i++) begin
            a[i]  = 32'h1000_0000 + 32'(i * 16);
            wd[i] = 32'hA000_0000 + 32'(i);
        end
        test_reset();
        test_contention();
        test_wrap();
        test_single();
        test_write_hold();
        test_reset_busy();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain left=%0d exp 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
